divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 139 +++++++++++++
 tb/tb_divider_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per RUN cycle, with
// single-cycle shortcuts for divide-by-zero and signed overflow.
module divider_seq #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] X,
  input  logic [SIZE-1:0] Y,
  output logic [SIZE-1:0] S,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [SIZE-1:0] div_q, div_d;
  logic [SIZE-1:0] rem_q, rem_d;
  logic [SIZE-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [SIZE-1:0] s_q, s_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            signed_op, x_neg, y_neg, no_borrow, res_neg;
  logic [SIZE-1:0] x_mag, y_mag, rem_step, quo_step, res_mag;
  logic [SIZE:0]   shifted;
  logic [SIZE+1:0] trial;

  // op[0] low selects the signed variants (DIV, REM)
  always_comb begin
    signed_op = ~op[0];
    x_neg     = signed_op & X[SIZE-1];
    y_neg     = signed_op & Y[SIZE-1];
    x_mag     = x_neg ? -X : X;
    y_mag     = y_neg ? -Y : Y;

    shifted   = {rem_q, quo_q[SIZE-1]};
    trial     = {1'b0, shifted} - {2'b00, div_q};
    no_borrow = ~trial[SIZE+1];
    rem_step  = no_borrow ? trial[SIZE-1:0] : shifted[SIZE-1:0];
    quo_step  = {quo_q[SIZE-2:0], no_borrow};
    res_mag   = op_q[1] ? rem_step : quo_step;
    res_neg   = ~op_q[0] & (op_q[1] ? rneg_q : qneg_q);

    state_d = state_q;
    op_d    = op_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    s_d     = s_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          if (Y == '0) begin
            s_d     = op[1] ? X : '1;
            state_d = DONE;
            done_d  = 1'b1;
          end else if (signed_op && X == {1'b1, {(SIZE-1){1'b0}}} && Y == '1) begin
            s_d     = op[1] ? '0 : X;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rem_d   = '0;
            quo_d   = x_mag;
            div_d   = y_mag;
            qneg_d  = x_neg ^ y_neg;
            rneg_d  = x_neg;
            cnt_d   = CW'(SIZE);
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        rem_d  = rem_step;
        quo_d  = quo_step;
        cnt_d  = cnt_q - CW'(1);
        busy_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          s_d     = res_neg ? -res_mag : res_mag;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq (SIZE=32): vector table plus hand-written
// sequences for start re-pulse, back-to-back operation and mid-RUN reset.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] X, Y, S;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  divider_seq #(.SIZE(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .X(X), .Y(Y), .S(S), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] s;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation and follows it until done (or a 100-edge bound).
  // lat counts the start edge as edge 1; returns at the negedge where done is seen.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] xIn, input logic [31:0] yIn,
                               input int repulseAt, output int lat, output int busyCycles,
                               output bit overlap, output bit seen);
    @(negedge clk);
    op = opIn; X = xIn; Y = yIn; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~opIn; X = 32'hA5A5_5A5A; Y = 32'h0;
    lat = 1; busyCycles = 0; overlap = 0; seen = 0;
    while (!seen && lat <= 100) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (busy && done) overlap = 1;
      if (done) seen = 1;
      else begin
        if (lat == repulseAt) begin
          start = 1'b1; op = 2'b01; X = 32'd9; Y = 32'd3;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
      end
    end
  endtask

  task automatic runVector(input string name, input logic [1:0] opIn, input logic [31:0] xIn,
                           input logic [31:0] yIn, input logic [31:0] expS, input int expLat,
                           input int repulseAt);
    int lat, busyCycles;
    bit overlap, seen;
    applyStimulus(opIn, xIn, yIn, repulseAt, lat, busyCycles, overlap, seen);
    checkOutput({name, " done_seen"}, 32'(seen), 32'd1);
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, " S"}, S, expS);
    checkOutput({name, " busy_cycles"}, 32'(busyCycles), 32'(expLat - 1));
    checkOutput({name, " busy_done_overlap"}, 32'(overlap), 32'd0);
  endtask

  initial begin
    int doneCount;

    vecs[0]  = '{"divu_100_7",     2'b01, 32'd100,       32'd7,         32'd14,        33};
    vecs[1]  = '{"remu_100_7",     2'b11, 32'd100,       32'd7,         32'd2,         33};
    vecs[2]  = '{"div_m7_2",       2'b00, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  33};
    vecs[3]  = '{"rem_m7_2",       2'b10, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  33};
    vecs[4]  = '{"div_by_zero",    2'b00, 32'h12345678,  32'd0,         32'hFFFFFFFF,  1};
    vecs[5]  = '{"rem_by_zero",    2'b10, 32'h12345678,  32'd0,         32'h12345678,  1};
    vecs[6]  = '{"divu_by_zero",   2'b01, 32'hCAFEF00D,  32'd0,         32'hFFFFFFFF,  1};
    vecs[7]  = '{"remu_by_zero",   2'b11, 32'hCAFEF00D,  32'd0,         32'hCAFEF00D,  1};
    vecs[8]  = '{"div_overflow",   2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
    vecs[9]  = '{"rem_overflow",   2'b10, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1};
    vecs[10] = '{"divu_min_ones",  2'b01, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  33};
    vecs[11] = '{"remu_min_ones",  2'b11, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  33};
    vecs[12] = '{"div_7_m2",       2'b00, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  33};
    vecs[13] = '{"rem_7_m2",       2'b10, 32'd7,         32'hFFFFFFFE,  32'd1,         33};
    vecs[14] = '{"div_m100_m7",    2'b00, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        33};
    vecs[15] = '{"rem_m100_m7",    2'b10, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'hFFFFFFFE,  33};
    vecs[16] = '{"divu_max_1",     2'b01, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  33};
    vecs[17] = '{"remu_big",       2'b11, 32'hFFFFFFFF,  32'h10000,     32'h0000FFFF,  33};

    reset = 1'b1; start = 1'b0; op = 2'b00; X = '0; Y = '0;
    #3;
    checkOutput("reset S", S, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      runVector(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].lat, -1);
      @(negedge clk);
      checkOutput({vecs[i].name, " done_one_cycle"}, 32'(done), 32'd0);
      checkOutput({vecs[i].name, " S_hold"}, S, vecs[i].s);
    end

    // start re-pulsed mid-RUN is ignored, then a back-to-back op in the first IDLE cycle
    runVector("repulse_divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 10);
    runVector("back_to_back_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33, -1);

    // asynchronous reset 15 cycles into RUN
    @(negedge clk);
    op = 2'b01; X = 32'd100; Y = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset busy", 32'(busy), 32'd0);
    checkOutput("async_reset done", 32'(done), 32'd0);
    checkOutput("async_reset S", S, 32'd0);
    #1 reset = 1'b0;
    doneCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    checkOutput("no_done_after_reset", 32'(doneCount), 32'd0);
    runVector("post_reset_divu_50_5", 2'b01, 32'd50, 32'd5, 32'd10, 33, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
